// File: rtl/pwm_hbridge_ctrl.sv
// Multi-channel H-bridge PWM controller: one shared period counter, double-buffered
// per-channel duty/mode applied at period wraps, and a coast interval on direction changes.
module pwm_hbridge_ctrl #(
    parameter int unsigned CH         = 2,
    parameter int unsigned DUTY_W     = 8,
    parameter int unsigned PERIOD     = 100,
    parameter int unsigned PRESCALE   = 500,
    parameter int unsigned DEAD_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH*DUTY_W-1:0] cfg_duty,
    input  logic [CH*2-1:0]      cfg_mode,
    output logic [CH-1:0]        in_a,
    output logic [CH-1:0]        in_b,
    output logic                 period_start
);
    localparam int unsigned PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned PH_W   = DUTY_W;
    localparam int unsigned DEAD_W = $clog2(DEAD_TICKS + 1);

    localparam logic [1:0] MODE_COAST = 2'b00;
    localparam logic [1:0] MODE_FWD   = 2'b01;
    localparam logic [1:0] MODE_REV   = 2'b10;
    localparam logic [1:0] MODE_BRAKE = 2'b11;

    typedef enum logic {ST_NORMAL, ST_DEAD} state_e;

    logic [PRE_W-1:0]     pre_cnt_q, pre_cnt_d;
    logic [PH_W-1:0]      ph_q, ph_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic [CH*DUTY_W-1:0] pend_duty_q, pend_duty_d, act_duty_q, act_duty_d;
    logic [CH*2-1:0]      pend_mode_q, pend_mode_d, act_mode_q, act_mode_d;
    state_e               state_q [CH];
    state_e               state_d [CH];
    logic [DEAD_W-1:0]    dead_cnt_q [CH];
    logic [DEAD_W-1:0]    dead_cnt_d [CH];
    logic [CH-1:0]        in_a_q, in_a_d, in_b_q, in_b_d;
    logic                 period_start_q, period_start_d;
    logic [CH-1:0]        pwm;

    logic tick, wrap, apply, take;

    assign tick  = en && (pre_cnt_q == PRE_W'(PRESCALE - 1));
    assign wrap  = tick && (ph_q == PH_W'(PERIOD - 1));
    assign apply = wrap && !cfg_ready_q;
    assign take  = cfg_valid && cfg_ready_q;

    assign cfg_ready    = cfg_ready_q;
    assign in_a         = in_a_q;
    assign in_b         = in_b_q;
    assign period_start = period_start_q;

    // Only a switch between two driven modes can shoot through a leg.
    function automatic logic needs_dead(input logic [1:0] old_m, input logic [1:0] new_m);
        return (old_m != new_m) && (old_m != MODE_COAST) && (new_m != MODE_COAST);
    endfunction

    always_comb begin
        pre_cnt_d      = pre_cnt_q;
        ph_d           = ph_q;
        cfg_ready_d    = cfg_ready_q;
        pend_duty_d    = pend_duty_q;
        pend_mode_d    = pend_mode_q;
        act_duty_d     = act_duty_q;
        act_mode_d     = act_mode_q;
        state_d        = state_q;
        dead_cnt_d     = dead_cnt_q;
        in_a_d         = '0;
        in_b_d         = '0;
        pwm            = '0;
        period_start_d = wrap;

        if (!en) begin
            pre_cnt_d = '0;
            ph_d      = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
            ph_d      = wrap ? '0 : ph_q + PH_W'(1);
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end

        // take and apply are mutually exclusive: one needs ready high, the other low.
        if (apply) begin
            act_duty_d  = pend_duty_q;
            act_mode_d  = pend_mode_q;
            cfg_ready_d = 1'b1;
        end
        if (take) begin
            pend_duty_d = cfg_duty;
            pend_mode_d = cfg_mode;
            cfg_ready_d = 1'b0;
        end

        for (int i = 0; i < CH; i++) begin
            if (!en) begin
                state_d[i]    = ST_NORMAL;
                dead_cnt_d[i] = '0;
            end else begin
                case (state_q[i])
                    ST_NORMAL: begin
                        if (apply && needs_dead(act_mode_q[2*i +: 2], act_mode_d[2*i +: 2])) begin
                            state_d[i]    = ST_DEAD;
                            dead_cnt_d[i] = DEAD_W'(DEAD_TICKS);
                        end
                    end
                    ST_DEAD: begin
                        if (apply) begin
                            dead_cnt_d[i] = DEAD_W'(DEAD_TICKS);
                        end else if (tick) begin
                            if (dead_cnt_q[i] <= DEAD_W'(1)) begin
                                state_d[i]    = ST_NORMAL;
                                dead_cnt_d[i] = '0;
                            end else begin
                                dead_cnt_d[i] = dead_cnt_q[i] - DEAD_W'(1);
                            end
                        end
                    end
                    default: state_d[i] = ST_NORMAL;
                endcase
            end

            // Outputs are registered from next-state values so they line up with period_start.
            pwm[i] = (ph_d < act_duty_d[i*DUTY_W +: DUTY_W]);
            if (en && state_d[i] == ST_NORMAL) begin
                case (act_mode_d[2*i +: 2])
                    MODE_FWD:   in_a_d[i] = pwm[i];
                    MODE_REV:   in_b_d[i] = pwm[i];
                    MODE_BRAKE: begin
                        in_a_d[i] = 1'b1;
                        in_b_d[i] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q      <= '0;
            ph_q           <= '0;
            cfg_ready_q    <= 1'b1;
            pend_duty_q    <= '0;
            pend_mode_q    <= '0;
            act_duty_q     <= '0;
            act_mode_q     <= '0;
            in_a_q         <= '0;
            in_b_q         <= '0;
            period_start_q <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                state_q[i]    <= ST_NORMAL;
                dead_cnt_q[i] <= '0;
            end
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            ph_q           <= ph_d;
            cfg_ready_q    <= cfg_ready_d;
            pend_duty_q    <= pend_duty_d;
            pend_mode_q    <= pend_mode_d;
            act_duty_q     <= act_duty_d;
            act_mode_q     <= act_mode_d;
            in_a_q         <= in_a_d;
            in_b_q         <= in_b_d;
            period_start_q <= period_start_d;
            for (int i = 0; i < CH; i++) begin
                state_q[i]    <= state_d[i];
                dead_cnt_q[i] <= dead_cnt_d[i];
            end
        end
    end

endmodule
